// File: rtl/mp_calc_arbiter_if.sv
// mp_calc_arbiter_if
// Bundles the two requester ports and the shared calculation unit port of
// mp_calc_arbiter. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding requesters and calculation unit.
interface mp_calc_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 4
);

  // requester 0
  logic                  req0;
  logic [OPC_W-1:0]      opc0;
  logic [DATA_W-1:0]     a0;
  logic [DATA_W-1:0]     b0;
  logic                  gnt0;
  logic                  done0;
  logic                  err0;

  // requester 1
  logic                  req1;
  logic [OPC_W-1:0]      opc1;
  logic [DATA_W-1:0]     a1;
  logic [DATA_W-1:0]     b1;
  logic                  gnt1;
  logic                  done1;
  logic                  err1;

  // shared result back to whichever requester was served
  logic [2*DATA_W-1:0]   result;

  // calculation unit
  logic                  u_start;
  logic [OPC_W-1:0]      u_opc;
  logic [DATA_W-1:0]     u_a;
  logic [DATA_W-1:0]     u_b;
  logic                  u_abort;
  logic                  u_done;
  logic [2*DATA_W-1:0]   u_result;

  modport master (
    input  req0, opc0, a0, b0,
    input  req1, opc1, a1, b1,
    output gnt0, done0, err0,
    output gnt1, done1, err1,
    output result,
    output u_start, u_opc, u_a, u_b, u_abort,
    input  u_done, u_result
  );

  modport slave (
    output req0, opc0, a0, b0,
    output req1, opc1, a1, b1,
    input  gnt0, done0, err0,
    input  gnt1, done1, err1,
    input  result,
    input  u_start, u_opc, u_a, u_b, u_abort,
    output u_done, u_result
  );

endinterface

// File: rtl/mp_calc_arbiter.sv
// mp_calc_arbiter
// Round-robin arbiter and sequencer sharing one multi-cycle calculation unit
// between two requesters. The winner's command is latched, the unit is started
// with a one-cycle pulse, and its result is returned with a one-cycle done.
//
// Optional feature macro: CALC_TIMEOUT_EN
//   defined   : a watchdog aborts an operation after TIMEOUT WAIT cycles without
//               u_done; the requester sees done together with err, result = 0.
//   undefined : WAIT waits indefinitely; err0/err1/u_abort are tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | sample requests, pick winner, latch its command
// ISSUE | one-cycle u_start to the unit, watchdog cleared
// WAIT  | wait for u_done (or watchdog limit), capture result
// RESP  | one-cycle done (and err) to winner, hand priority to the other
module mp_calc_arbiter #(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  mp_calc_arbiter_if.master bus
);

  // the watchdog counter is 8 bits wide, so the limit must fit in 1..255
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mp_calc_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                win_q, win_d;
  logic [OPC_W-1:0]    opc_q, opc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                sel;

`ifdef CALC_TIMEOUT_EN
  localparam int            CNT_W       = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                abort;
`endif

  // winner of a contested or single request; ptr only matters when both ask
  assign sel = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

  // next-state and datapath update logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    opc_d    = opc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef CALC_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
    abort    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          win_d   = sel;
          opc_d   = sel ? bus.opc1 : bus.opc0;
          a_d     = sel ? bus.a1   : bus.a0;
          b_d     = sel ? bus.b1   : bus.b0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef CALC_TIMEOUT_EN
        cnt_d = '0;
        err_d = 1'b0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // a completion arriving on the limit cycle still counts as success
        if (bus.u_done) begin
          result_d = bus.u_result;
          state_d  = S_RESP;
        end
`ifdef CALC_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CNT) begin
          abort    = 1'b1;
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        ptr_d   = ~win_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      opc_q    <= opc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  // watchdog counter and timeout flag registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign bus.gnt0    = (state_q != S_IDLE) && !win_q;
  assign bus.gnt1    = (state_q != S_IDLE) &&  win_q;
  assign bus.done0   = (state_q == S_RESP) && !win_q;
  assign bus.done1   = (state_q == S_RESP) &&  win_q;
  assign bus.u_start = (state_q == S_ISSUE);
  assign bus.u_opc   = opc_q;
  assign bus.u_a     = a_q;
  assign bus.u_b     = b_q;
  assign bus.result  = result_q;

`ifdef CALC_TIMEOUT_EN
  assign bus.err0    = (state_q == S_RESP) && !win_q && err_q;
  assign bus.err1    = (state_q == S_RESP) &&  win_q && err_q;
  assign bus.u_abort = abort;
`else
  assign bus.err0    = 1'b0;
  assign bus.err1    = 1'b0;
  assign bus.u_abort = 1'b0;
`endif

endmodule

// File: doc/mp_calc_arbiter.md
# mp_calc_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle calculation unit (ALU/multiplier with op_start/op_done handshake) between two requesting controllers. Latches the winner's opcode and operands, issues a one-cycle start pulse, waits for completion, returns the result with a done pulse, and optionally aborts hung operations with a watchdog. Sits between the per-core controllers and the shared calculation datapath.

## Interface
- DATA_W, 32, operand width
- OPC_W, 4, opcode width
- TIMEOUT, 255, watchdog limit in WAIT cycles (1..255); used only with the timeout feature
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  level request from requester 0 / 1
- opc0 / opc1  in  OPC_W  requester opcode
- a0, b0 / a1, b1  in  DATA_W  requester operands
- gnt0 / gnt1  out  1  requester owns the unit
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle timeout flag, coincident with done
- result  out  2*DATA_W  last captured result
- u_start  out  1  one-cycle start pulse to unit
- u_opc  out  OPC_W; u_a, u_b  out  DATA_W  latched command to unit
- u_abort  out  1  one-cycle abort pulse to unit
- u_done  in  1  unit completion
- u_result  in  2*DATA_W  unit result, valid with u_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding 00/01/10/11).
- Priority pointer ptr (1 bit): 0 favours requester 0. Reset value 0.
- IDLE: req sampled only here. None → stay. One → that requester wins. Both → ptr selects. Winner's opc/a/b latched into u_opc/u_a/u_b; winner id stored; go ISSUE.
- ISSUE: u_start=1 one cycle; go WAIT. Watchdog counter cleared.
- WAIT: u_done=1 → capture u_result into result, go RESP. Otherwise counter increments.
- RESP: done of winner =1 one cycle; ptr ← other requester; go IDLE.
- gnt of winner high from ISSUE through RESP inclusive; at most one gnt high.
- Request consumed by its done pulse; req still high in the following IDLE cycle is a new request (arbitrated against the other by updated ptr).
- req deasserted after grant: operation completes normally, done still pulses.
- u_done outside WAIT: ignored, result unchanged.
- reset_n=0 in any state: next edge → IDLE, ptr=0, counter=0, all outputs 0 (gnt*, done*, err*, u_start, u_abort, u_opc, u_a, u_b, result). In-flight unit completion after reset ignored.
- Illegal state: recover to IDLE.

## Timing
- req high at edge k while IDLE → gnt and u_start high in cycle after edge k (ISSUE); u_opc/u_a/u_b valid same cycle, stable until next grant.
- u_done first seen at edge m in WAIT → done/result valid cycle after m (RESP) → IDLE next cycle.
- Min turnaround: 1 (IDLE) + 1 (ISSUE) + ≥1 (WAIT) + 1 (RESP) = 4 cycles per operation when u_done arrives in first WAIT cycle.
- Back-to-back alternation with both requests held: grants strictly alternate 0,1,0,1...
- result holds until next capture (or timeout/reset).

## Configuration
- CALC_TIMEOUT_EN defined: in WAIT, counter reaching TIMEOUT without u_done → u_abort=1 one cycle, result ← 0, go RESP with err of winner =1 alongside done. u_done in same cycle as limit wins (normal completion, no error).
- Not defined: WAIT waits indefinitely; counter absent; err0, err1, u_abort tied 0.

## Test plan
- Reset: reset_n=0 for 2 cycles mid-WAIT → all outputs 0, state IDLE; stale u_done next cycle → no done pulse.
- Single request: req0=1, opc0=2, a0=7, b0=6, unit returns u_done with u_result=42 after 3 cycles → u_start one cycle after req, gnt0 for 6 cycles, done0 pulse, result=42, gnt1 never high.
- Simultaneous: req0=req1=1 held for 4 operations from reset → service order 0,1,0,1; u_a tracks a0,a1,a0,a1.
- Priority after service: served 0, then only req0 high, then req1 also rises → req1 wins next arbitration.
- Spurious done: u_done pulsed in IDLE and ISSUE → ignored; operation completes only on later u_done in WAIT.
- Timeout (CALC_TIMEOUT_EN, TIMEOUT=8): unit never responds → u_abort pulse after 8 WAIT cycles, done1 and err1 together, result=0; without macro same stimulus → gnt1 held, no done.
